// File: rtl/axi4l_pkg.sv
// ----------------------------------------------------------------------------
// axi4l_pkg
// Shared definitions for the AXI4-Lite register bank:
//   - RESP_OKAY / RESP_SLVERR response encodings
//   - write-engine and read-engine state encodings
//   - log2_fn: constant log2 used to derive the byte-offset width of an address
// ----------------------------------------------------------------------------
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // floor(log2(v)); v is a power of two in every use here
    function automatic int unsigned log2_fn(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) <= v) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4l_reg_bank_wr_ctrl.sv
// ----------------------------------------------------------------------------
// axi4l_reg_bank_wr_ctrl
// AW/W capture FSM and B response logic of the register bank. AW and W are
// captured independently; once both are held the transaction commits for one
// cycle (commit_o) and the response is raised on the same edge the register
// updates.
//
// Optional feature macro: AXI4L_REG_BANK_WSTRB_EN
//   defined   : captured strobe is wstrb_i
//   undefined : wstrb_i ignored, captured strobe is all ones
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   awaddr_i/awvalid_i/awready_o      write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o write data channel
//   bresp_o/bvalid_o/bready_i         write response channel
//   commit_o                          one-cycle commit strobe to storage
//   idx_o/data_o/strb_o/err_o         committed index, data, strobe, error flag
// ----------------------------------------------------------------------------
module axi4l_reg_bank_wr_ctrl
    import axi4l_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 8,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
    localparam int unsigned         LSB        = log2_fn(DATA_WIDTH / 8),
    localparam int unsigned         IW         = ADDR_WIDTH - LSB
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_WIDTH-1:0]     awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic                      commit_o,
    output logic [IW-1:0]             idx_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic [DATA_WIDTH/8-1:0]   strb_o,
    output logic                      err_o
);

    wr_state_e                 state_q;
    logic                      aw_got_q;
    logic                      w_got_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic [IW-1:0]             idx_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;

    logic                      aw_fire;
    logic                      w_fire;
    logic                      err;
    logic [DATA_WIDTH/8-1:0]   strb_d;
    logic                      unused_ok;

    assign aw_fire = awvalid_i & awready_q;
    assign w_fire  = wvalid_i & wready_q;

`ifdef AXI4L_REG_BANK_WSTRB_EN
    assign strb_d    = wstrb_i;
    assign unused_ok = ^awaddr_i[LSB-1:0];
`else
    assign strb_d    = '1;
    assign unused_ok = ^{awaddr_i[LSB-1:0], wstrb_i};
`endif

    // Out-of-range index and read-only targets both reject the write
    always_comb begin
        err = 1'b1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(idx_q) == i) err = RO_MASK[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            idx_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_got_q  <= 1'b1;
                        awready_q <= 1'b0;
                        idx_q     <= awaddr_i[ADDR_WIDTH-1:LSB];
                    end
                    if (w_fire) begin
                        w_got_q  <= 1'b1;
                        wready_q <= 1'b0;
                        data_q   <= wdata_i;
                        strb_q   <= strb_d;
                    end
                    if ((aw_got_q | aw_fire) && (w_got_q | w_fire)) begin
                        state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    // First W_RESP cycle is the commit cycle; response rises with it
                    if (!bvalid_q) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= err ? RESP_SLVERR : RESP_OKAY;
                    end else if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        state_q   <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign commit_o  = (state_q == W_RESP) && !bvalid_q;
    assign idx_o     = idx_q;
    assign data_o    = data_q;
    assign strb_o    = strb_q;
    assign err_o     = err;

endmodule

// File: rtl/axi4l_reg_bank.sv
// ----------------------------------------------------------------------------
// axi4l_reg_bank
// AXI4-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits.
// Registers flagged in RO_MASK are read-only and read back from i_status.
// Illegal accesses (out of range, write to RO) answer SLVERR.
// Write engine lives in axi4l_reg_bank_wr_ctrl; read engine and storage here.
//
// Optional feature macro: AXI4L_REG_BANK_WSTRB_EN (byte-lane write strobes;
// when undefined every OKAY write updates the full word).
//
// Ports:
//   i_axi_clock, i_axi_reset      clock, synchronous active-high reset
//   i_axi_aw*/o_axi_awaddr_ready  write address channel (prot ignored)
//   i_axi_w*/o_axi_wdata_ready    write data channel
//   o_axi_b*/i_axi_bready         write response channel
//   i_axi_ar*/o_axi_araddr_ready  read address channel (prot ignored)
//   o_axi_r*/i_axi_rdata_ready    read data channel
//   o_regs                        flattened RW register contents
//   i_status                      read values for RO registers
//   o_wr_pulse / o_rd_pulse       per-register access pulses
// ----------------------------------------------------------------------------
module axi4l_reg_bank
    import axi4l_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          NUM_REGS   = 8,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                            i_axi_clock,
    input  logic                            i_axi_reset,
    input  logic [ADDR_WIDTH-1:0]           i_axi_awaddr,
    input  logic [2:0]                      i_axi_awprot,
    input  logic                            i_axi_awaddr_valid,
    output logic                            o_axi_awaddr_ready,
    input  logic [DATA_WIDTH-1:0]           i_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]         i_axi_wstrb,
    input  logic                            i_axi_wdata_valid,
    output logic                            o_axi_wdata_ready,
    output logic [1:0]                      o_axi_bresp,
    output logic                            o_axi_bvalid,
    input  logic                            i_axi_bready,
    input  logic [ADDR_WIDTH-1:0]           i_axi_araddr,
    input  logic [2:0]                      i_axi_arprot,
    input  logic                            i_axi_araddr_valid,
    output logic                            o_axi_araddr_ready,
    output logic [DATA_WIDTH-1:0]           o_axi_rdata,
    output logic [1:0]                      o_axi_rresp,
    output logic                            o_axi_rdata_valid,
    input  logic                            i_axi_rdata_ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  o_regs,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]  i_status,
    output logic [NUM_REGS-1:0]             o_wr_pulse,
    output logic [NUM_REGS-1:0]             o_rd_pulse
);

    localparam int unsigned LSB   = log2_fn(DATA_WIDTH / 8);
    localparam int unsigned IW    = ADDR_WIDTH - LSB;
    localparam int unsigned NBYTE = DATA_WIDTH / 8;

    // ---------------- write engine ----------------
    logic                  wr_commit;
    logic [IW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTE-1:0]      wr_strb;
    logic                  wr_err;

    axi4l_reg_bank_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RO_MASK    (RO_MASK)
    ) u_wr_ctrl (
        .clk_i     (i_axi_clock),
        .rst_i     (i_axi_reset),
        .awaddr_i  (i_axi_awaddr),
        .awvalid_i (i_axi_awaddr_valid),
        .awready_o (o_axi_awaddr_ready),
        .wdata_i   (i_axi_wdata),
        .wstrb_i   (i_axi_wstrb),
        .wvalid_i  (i_axi_wdata_valid),
        .wready_o  (o_axi_wdata_ready),
        .bresp_o   (o_axi_bresp),
        .bvalid_o  (o_axi_bvalid),
        .bready_i  (i_axi_bready),
        .commit_o  (wr_commit),
        .idx_o     (wr_idx),
        .data_o    (wr_data),
        .strb_o    (wr_strb),
        .err_o     (wr_err)
    );

    // ---------------- register storage ----------------
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic [NUM_REGS-1:0]   wr_sel;

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = (32'(wr_idx) == i);
        end
    end

    always_ff @(posedge i_axi_clock) begin
        if (i_axi_reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit && !wr_err) begin
                wr_pulse_q <= wr_sel;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_sel[i]) begin
                        for (int unsigned b = 0; b < NBYTE; b++) begin
                            if (wr_strb[b]) regs_q[i][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            o_regs[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign o_wr_pulse = wr_pulse_q;

    // ---------------- read engine ----------------
    rd_state_e             rd_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REGS-1:0]   rd_pulse_q;

    logic [IW-1:0]         rd_idx;
    logic [NUM_REGS-1:0]   rd_sel;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_err;
    logic                  ar_fire;

    assign rd_idx  = i_axi_araddr[ADDR_WIDTH-1:LSB];
    assign ar_fire = i_axi_araddr_valid & arready_q;

    // Sampling regs_q here means a write committing on the same edge is not
    // yet visible: the read returns the pre-write value.
    always_comb begin
        rd_sel = '0;
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_idx) == i) begin
                rd_sel[i] = 1'b1;
                rd_val    = RO_MASK[i] ? i_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
        rd_err = ~|rd_sel;
    end

    always_ff @(posedge i_axi_clock) begin
        if (i_axi_reset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_pulse_q <= '0;
        end else begin
            rd_pulse_q <= '0;
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_val;
                        rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rd_pulse_q <= rd_sel;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_axi_rdata_ready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign o_axi_araddr_ready = arready_q;
    assign o_axi_rdata_valid  = rvalid_q;
    assign o_axi_rresp        = rresp_q;
    assign o_axi_rdata        = rdata_q;
    assign o_rd_pulse         = rd_pulse_q;

    logic unused_ok;
    assign unused_ok = ^{i_axi_awprot, i_axi_arprot, i_axi_araddr[LSB-1:0], i_status};

endmodule

// File: tb/tb_axi4l_reg_bank.sv
module tb_axi4l_reg_bank;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [NR*DW-1:0] regs;
    logic [NR*DW-1:0] status;
    logic [NR-1:0]   wr_pulse;
    logic [NR-1:0]   rd_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_regs [NR];

    always #5 clk = ~clk;

    axi4l_reg_bank #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .RO_MASK    (8'h80)
    ) dut (
        .i_axi_clock        (clk),
        .i_axi_reset        (rst),
        .i_axi_awaddr       (awaddr),
        .i_axi_awprot       (awprot),
        .i_axi_awaddr_valid (awvalid),
        .o_axi_awaddr_ready (awready),
        .i_axi_wdata        (wdata),
        .i_axi_wstrb        (wstrb),
        .i_axi_wdata_valid  (wvalid),
        .o_axi_wdata_ready  (wready),
        .o_axi_bresp        (bresp),
        .o_axi_bvalid       (bvalid),
        .i_axi_bready       (bready),
        .i_axi_araddr       (araddr),
        .i_axi_arprot       (arprot),
        .i_axi_araddr_valid (arvalid),
        .o_axi_araddr_ready (arready),
        .o_axi_rdata        (rdata),
        .o_axi_rresp        (rresp),
        .o_axi_rdata_valid  (rvalid),
        .i_axi_rdata_ready  (rready),
        .o_regs             (regs),
        .i_status           (status),
        .o_wr_pulse         (wr_pulse),
        .o_rd_pulse         (rd_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] flat_exp();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
        return v;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                            output logic [1:0] resp, output logic [NR-1:0] pulse);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 20 && !bvalid; k++) tick();
        chk("b_wait", {255'b0, bvalid}, 256'd1);
        resp = bresp;
        pulse = wr_pulse;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int k = 0; k < 20 && !rvalid; k++) tick();
        chk("r_wait", {255'b0, rvalid}, 256'd1);
        d = rdata;
        resp = rresp;
        pulse = rd_pulse;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
        logic [DW-1:0] d;
        logic [DW-1:0] strb_exp;

        rst = 1'b1;
        awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b001; arvalid = 1'b0; rready = 1'b0;
        status = '0;
        status[7*DW +: DW] = 32'h0000CAFE;
        status[0 +: DW]    = 32'hFFFF0000;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;

        tick(); tick();
        rst = 1'b0;
        chk("rst_awready", {255'b0, awready}, 256'd1);
        chk("rst_wready",  {255'b0, wready},  256'd1);
        chk("rst_arready", {255'b0, arready}, 256'd1);
        chk("rst_bvalid",  {255'b0, bvalid},  256'd0);
        chk("rst_rvalid",  {255'b0, rvalid},  256'd0);
        chk("rst_bresp",   {254'b0, bresp},   256'd0);
        chk("rst_rresp",   {254'b0, rresp},   256'd0);
        chk("rst_rdata",   {224'b0, rdata},   256'd0);
        chk("rst_regs",    regs,              256'd0);
        chk("rst_pulses",  {240'b0, wr_pulse, rd_pulse}, 256'd0);
        tick();

        // AW and W in the same cycle
        awaddr = 8'h04; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_awready_low", {255'b0, awready}, 256'd0);
        chk("t1_wready_low",  {255'b0, wready},  256'd0);
        chk("t1_bvalid_early", {255'b0, bvalid}, 256'd0);
        chk("t1_regs_early",   regs, 256'd0);
        tick();
        exp_regs[1] = 32'hDEADBEEF;
        chk("t1_bvalid",   {255'b0, bvalid}, 256'd1);
        chk("t1_bresp",    {254'b0, bresp},  256'd0);
        chk("t1_regs",     regs, flat_exp());
        chk("t1_wr_pulse", {248'b0, wr_pulse}, 256'h02);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("t1_bvalid_done", {255'b0, bvalid},   256'd0);
        chk("t1_pulse_gone",  {248'b0, wr_pulse}, 256'd0);
        chk("t1_ready_back",  {254'b0, awready, wready}, 256'd3);

        araddr = 8'h04; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("t1_rvalid",   {255'b0, rvalid},  256'd1);
        chk("t1_rdata",    {224'b0, rdata},   256'hDEADBEEF);
        chk("t1_rresp",    {254'b0, rresp},   256'd0);
        chk("t1_rd_pulse", {248'b0, rd_pulse}, 256'h02);
        chk("t1_arready",  {255'b0, arready}, 256'd0);
        araddr = 8'h00;
        tick();
        chk("t1_rvalid_hold", {255'b0, rvalid}, 256'd1);
        chk("t1_rdata_hold",  {224'b0, rdata},  256'hDEADBEEF);
        chk("t1_rd_pulse_1c", {248'b0, rd_pulse}, 256'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("t1_rvalid_done", {255'b0, rvalid},  256'd0);
        chk("t1_arready_back", {255'b0, arready}, 256'd1);

        // W three cycles before AW, bready held low for four cycles
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("t2_wready_low",  {255'b0, wready},  256'd0);
        chk("t2_awready_high", {255'b0, awready}, 256'd1);
        tick(); tick();
        awaddr = 8'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t2_awready_low", {255'b0, awready}, 256'd0);
        chk("t2_bvalid_early", {255'b0, bvalid}, 256'd0);
        exp_regs[3] = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t2_bvalid_held", {255'b0, bvalid}, 256'd1);
            chk("t2_readies_low", {254'b0, awready, wready}, 256'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("t2_bvalid_done", {255'b0, bvalid}, 256'd0);
        chk("t2_readies_back", {254'b0, awready, wready}, 256'd3);
        chk("t2_regs", regs, flat_exp());

        // Byte strobes
        do_write(8'h08, 32'h11223344, 4'hF, resp, pulse);
        exp_regs[2] = 32'h11223344;
        chk("t3_base", regs, flat_exp());
        do_write(8'h08, 32'hAABBCCDD, 4'b0101, resp, pulse);
`ifdef AXI4L_REG_BANK_WSTRB_EN
        strb_exp = 32'h11BB33DD;
`else
        strb_exp = 32'hAABBCCDD;
`endif
        exp_regs[2] = strb_exp;
        chk("t3_bresp", {254'b0, resp}, 256'd0);
        chk("t3_pulse", {248'b0, pulse}, 256'h04);
        chk("t3_regs",  regs, flat_exp());

        // Read-only register 7
        do_write(8'h1C, 32'h55555555, 4'hF, resp, pulse);
        chk("t4_wr_slverr", {254'b0, resp},  256'd2);
        chk("t4_wr_nopulse", {248'b0, pulse}, 256'd0);
        chk("t4_regs",      regs, flat_exp());
        do_read(8'h1C, d, resp, pulse);
        chk("t4_rdata", {224'b0, d},    256'h0000CAFE);
        chk("t4_rresp", {254'b0, resp}, 256'd0);
        chk("t4_rpulse", {248'b0, pulse}, 256'h80);

        // RW register ignores its status slice
        do_read(8'h00, d, resp, pulse);
        chk("t4b_rdata", {224'b0, d},    256'd0);
        chk("t4b_rpulse", {248'b0, pulse}, 256'h01);

        // Unaligned address bits ignored
        do_read(8'h0F, d, resp, pulse);
        chk("t4c_rdata", {224'b0, d}, 256'h12345678);

        // Out of range
        do_read(8'h20, d, resp, pulse);
        chk("t5_rresp", {254'b0, resp}, 256'd2);
        chk("t5_rdata", {224'b0, d},    256'd0);
        chk("t5_rpulse", {248'b0, pulse}, 256'd0);
        do_write(8'h20, 32'hFFFFFFFF, 4'hF, resp, pulse);
        chk("t5_bresp", {254'b0, resp},  256'd2);
        chk("t5_wpulse", {248'b0, pulse}, 256'd0);
        chk("t5_regs",  regs, flat_exp());

        // Read sampled on the same edge the write commits: pre-write value
        awaddr = 8'h14; awvalid = 1'b1;
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 8'h14; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        exp_regs[5] = 32'h5A5A5A5A;
        chk("t6_rvalid",   {255'b0, rvalid}, 256'd1);
        chk("t6_rdata_old", {224'b0, rdata}, 256'd0);
        chk("t6_bvalid",   {255'b0, bvalid}, 256'd1);
        chk("t6_regs_new", regs, flat_exp());
        chk("t6_pulses",   {240'b0, wr_pulse, rd_pulse}, 256'h2020);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // Reset with both responses pending
        awaddr = 8'h08; awvalid = 1'b1;
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 8'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        chk("t7_bvalid_pre", {255'b0, bvalid}, 256'd1);
        chk("t7_rvalid_pre", {255'b0, rvalid}, 256'd1);
        rst = 1'b1;
        tick();
        chk("t7_bvalid",  {255'b0, bvalid}, 256'd0);
        chk("t7_rvalid",  {255'b0, rvalid}, 256'd0);
        chk("t7_regs",    regs, 256'd0);
        chk("t7_readies", {253'b0, awready, wready, arready}, 256'd7);
        chk("t7_rdata",   {224'b0, rdata}, 256'd0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
